// File: rtl/vga_timing_generator.sv
// VGA horizontal + vertical timing generator with pixel-clock enable.
// Counters and all decoded outputs are registered together (zero skew).
module vga_timing_generator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_PULSE  = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_PULSE  = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    output logic             h_sync,
    output logic             v_sync,
    output logic             display_en,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_PULSE + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_PULSE + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_PULSE);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_PULSE);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             hs_nxt;
    logic             vs_nxt;
    logic             de_nxt;

    // Decode from the next position so outputs line up with the counters.
    always_comb begin
        h_wrap = (h_count == H_LAST);
        v_wrap = (v_count == V_LAST);
        h_nxt  = h_wrap ? '0 : h_count + 1'b1;
        v_nxt  = v_count;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : v_count + 1'b1;
        end
        hs_nxt = (h_nxt >= HS_BEG && h_nxt < HS_END) ? HS_ON : ~HS_ON;
        vs_nxt = (v_nxt >= VS_BEG && v_nxt < VS_END) ? VS_ON : ~VS_ON;
        de_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_count     <= '0;
            v_count     <= '0;
            h_sync      <= ~HS_ON;
            v_sync      <= ~VS_ON;
            display_en  <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            h_count     <= h_nxt;
            v_count     <= v_nxt;
            h_sync      <= hs_nxt;
            v_sync      <= vs_nxt;
            display_en  <= de_nxt;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator: four instances (default, inverted
// polarity, tiny 8x5 raster, 16-pixel lines with default vertical timing).
module tb_vga_timing_generator;

    logic clk = 1'b0;
    logic rst;
    logic pix_ce;

    logic [3:0] hs, vs, de, ls, fs;
    logic [9:0] hc [4];
    logic [9:0] vc [4];
    logic [24:0] obs [4];

    always #5 clk = ~clk;

    vga_timing_generator u_def (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .h_sync(hs[0]), .v_sync(vs[0]), .display_en(de[0]),
        .h_count(hc[0]), .v_count(vc[0]),
        .line_start(ls[0]), .frame_start(fs[0])
    );

    vga_timing_generator #(.HS_POL(1), .VS_POL(1)) u_pol (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .h_sync(hs[1]), .v_sync(vs[1]), .display_en(de[1]),
        .h_count(hc[1]), .v_count(vc[1]),
        .line_start(ls[1]), .frame_start(fs[1])
    );

    vga_timing_generator #(
        .H_ACTIVE(4), .H_FP(1), .H_PULSE(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_PULSE(1), .V_BP(1)
    ) u_small (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .h_sync(hs[2]), .v_sync(vs[2]), .display_en(de[2]),
        .h_count(hc[2]), .v_count(vc[2]),
        .line_start(ls[2]), .frame_start(fs[2])
    );

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_PULSE(4), .H_BP(2)
    ) u_vert (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .h_sync(hs[3]), .v_sync(vs[3]), .display_en(de[3]),
        .h_count(hc[3]), .v_count(vc[3]),
        .line_start(ls[3]), .frame_start(fs[3])
    );

    for (genvar g = 0; g < 4; g++) begin : g_obs
        assign obs[g] = {hs[g], vs[g], de[g], ls[g], fs[g], hc[g], vc[g]};
    end

    // Hand-derived raster constants for each instance.
    int   HT  [4] = '{800, 800, 8, 16};
    int   VT  [4] = '{525, 525, 5, 525};
    int   HSL [4] = '{656, 656, 5, 10};
    int   HSH [4] = '{752, 752, 7, 14};
    int   VSL [4] = '{490, 490, 3, 490};
    int   VSH [4] = '{492, 492, 4, 492};
    int   HA  [4] = '{640, 640, 4, 8};
    int   VA  [4] = '{480, 480, 2, 480};
    logic POL [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    int   mh [4];
    int   mv [4];
    logic mls [4];
    logic mfs [4];

    int n_chk = 0;
    int n_err = 0;
    int ls0_cnt;
    int fs2_cnt;
    int fs3_cnt;

    function automatic logic [24:0] expv(int i);
        logic hs_e, vs_e, de_e;
        hs_e = (mh[i] >= HSL[i] && mh[i] < HSH[i]) ? POL[i] : ~POL[i];
        vs_e = (mv[i] >= VSL[i] && mv[i] < VSH[i]) ? POL[i] : ~POL[i];
        de_e = (mh[i] < HA[i]) && (mv[i] < VA[i]);
        return {hs_e, vs_e, de_e, mls[i], mfs[i], 10'(mh[i]), 10'(mv[i])};
    endfunction

    task automatic check(input string tag, input logic [31:0] o,
                         input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step(input logic c, input logic r);
        pix_ce = c;
        rst    = r;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            mls[i] = 1'b0;
            mfs[i] = 1'b0;
            if (r) begin
                mh[i] = 0;
                mv[i] = 0;
            end else if (c) begin
                mh[i] = mh[i] + 1;
                if (mh[i] == HT[i]) begin
                    mh[i]  = 0;
                    mls[i] = 1'b1;
                    mv[i]  = mv[i] + 1;
                    if (mv[i] == VT[i]) begin
                        mv[i]  = 0;
                        mfs[i] = 1'b1;
                    end
                end
            end
            check($sformatf("pos%0d", i), 32'(obs[i]), 32'(expv(i)));
        end
        if (ls[0] === 1'b1) ls0_cnt++;
        if (fs[2] === 1'b1) fs2_cnt++;
        if (fs[3] === 1'b1) fs3_cnt++;
    endtask

    initial begin
        rst    = 1'b1;
        pix_ce = 1'b0;
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("rst_pol_syncs", 32'({hs[1], vs[1]}), 32'b00);
        check("rst_def_syncs", 32'({hs[0], vs[0], de[0]}), 32'b111);

        ls0_cnt = 0;
        for (int k = 0; k < 800; k++) step(1'b1, 1'b0);
        check("line_start_cnt", 32'(ls0_cnt), 32'd1);

        for (int k = 0; k < 12; k++) step(k[0] ? 1'b0 : 1'b1, 1'b0);
        check("toggle_hcount", 32'(hc[0]), 32'd6);

        step(1'b1, 1'b1);
        fs2_cnt = 0;
        fs3_cnt = 0;
        for (int k = 0; k < 8400; k++) step(1'b1, 1'b0);
        check("frame_start_cnt", 32'(fs3_cnt), 32'd1);
        check("small_frame_cnt", 32'(fs2_cnt), 32'd210);
        check("frame_end_strobes", 32'({ls[3], fs[3]}), 32'b11);

        for (int k = 0; k < 9000; k++) begin
            if (mh[3] == 12 && mv[3] == 491) break;
            step(1'b1, 1'b0);
        end
        check("pre_rst_pos", 32'({hs[3], vs[3], hc[3], vc[3]}),
              32'({2'b00, 10'd12, 10'd491}));
        step(1'b1, 1'b1);
        check("mid_rst", 32'(obs[3]), 32'({5'b11100, 10'd0, 10'd0}));
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Parametrised successor to the horizontal-only sync block: one module generates both horizontal and vertical VGA timing.
- Owns the pixel/line counters internally.
- Outputs both syncs with selectable polarity, a display-enable, pixel coordinates and line/frame start strobes.
- Sits between the clock divider and the pixel/framebuffer fetch logic.
- A pixel-clock-enable input lets it run on the 50 MHz system clock at a divided pixel rate.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_PULSE, 96, horizontal sync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_PULSE, 2, vertical sync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, h_sync active level (0 = active-low)
VS_POL, 0, v_sync active level (0 = active-low)
CNT_W, 10, counter width; must satisfy 2^CNT_W >= max(H_TOTAL, V_TOTAL)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pix_ce  in  1  pixel clock enable; timing advances only on cycles where pix_ce=1
h_sync  out  1  horizontal sync, level per HS_POL
v_sync  out  1  vertical sync, level per VS_POL
display_en  out  1  1 while the position is inside the active area
h_count  out  CNT_W  current pixel position within line, 0..H_TOTAL-1
v_count  out  CNT_W  current line within frame, 0..V_TOTAL-1
line_start  out  1  one-clk strobe when h_count becomes 0
frame_start  out  1  one-clk strobe when (h_count,v_count) becomes (0,0)

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_PULSE+H_BP (800 default); V_TOTAL = V_ACTIVE+V_FP+V_PULSE+V_BP (525 default).
- All outputs are registered. Every output describes the position held in h_count/v_count in the same cycle: zero skew between syncs, display_en and counters.
  - Implementation computes the next position combinationally and registers counters and decoded outputs together.
- Reset (rst=1 at posedge clk, overrides pix_ce):
  - h_count=0, v_count=0.
  - display_en=1 (position 0,0 is active).
  - h_sync=~HS_POL, v_sync=~VS_POL (inactive).
  - line_start=0, frame_start=0.
- pix_ce=0: counters, syncs and display_en hold their values; line_start and frame_start are 0.
- pix_ce=1, horizontal counter:
  - h_count increments by 1.
  - At H_TOTAL-1 it wraps to 0 and v_count advances.
- Vertical counter: v_count increments by 1 on each horizontal wrap. At V_TOTAL-1 it wraps to 0 on that same horizontal wrap.
- Sync windows:
  - h_sync = HS_POL when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_PULSE, else ~HS_POL. Default: active for h_count 656..751.
  - v_sync = VS_POL when V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_PULSE, else ~VS_POL. Default: active for v_count 490..491, whole lines.
- display_en = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
- Strobes:
  - line_start=1 for exactly the one clk in which h_count has just been loaded with 0 by a wrap.
  - frame_start=1 for the clk in which both counters have just been loaded with 0 by a wrap; line_start is also 1 in that clk.
  - Strobes are not asserted out of reset.
- Arithmetic: all comparisons are unsigned at CNT_W bits. No internal counter value outside 0..TOTAL-1 is ever reachable.
- Reset mid-frame: the next clk shows the reset values; timing restarts at (0,0) with no partial sync pulse carried over.

Test Plan:
- Reset, then pix_ce=1 continuously for 800 clks -> h_sync=1 for h_count 0..655, 0 for 656..751, 1 for 752..799; display_en=1 for h_count 0..639 on line 0; line_start=1 exactly once, when h_count returns to 0.
- Run 525*800 enabled cycles -> v_sync=0 only on lines 490..491; frame_start=1 once, coincident with (0,0), and line_start=1 on that same clk; display_en=0 for all lines >=480.
- pix_ce toggled 1,0,1,0 -> h_count advances every other clk; all outputs hold on pix_ce=0 clks; no strobe is asserted on a held clk.
- Assert rst at h_count=700, v_count=491 (syncs active) -> next clk h_count=0, v_count=0, h_sync=1, v_sync=1, display_en=1, strobes=0.
- HS_POL=1, VS_POL=1 -> h_sync=1 only for h_count 656..751; v_sync=1 only on lines 490..491; reset value of both syncs is 0.
- Small parameter set (H_ACTIVE=4, H_FP=1, H_PULSE=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_PULSE=1, V_BP=1) -> H_TOTAL=8, V_TOTAL=5; h_sync active at h_count 5..6; v_sync active on line 3; frame wraps every 40 enabled clks.
